pmod_enc_array: RTL and testbench
=================================

PMOD_ENC_ARRAY -- requirements
Module: pmod_enc_array

Interface
REQ-001 Parameter NUM_CH, default 3: number of encoder channels (1..8).
REQ-002 Parameter CNT_W, default 8: width of each channel count (4..16).
REQ-003 Parameter MAX_VAL, default {8'd255,8'd119,8'd159}: per-channel upper limit, packed NUM_CH*CNT_W, ch0 in LSBs.
REQ-004 Parameter WRAP, default 3'b100: per-channel mode bit, 1 = wrap around, 0 = saturate.
REQ-005 Parameter DB_CYCLES, default 1000: cycles an input must stay stable before it is accepted (>=2).
REQ-006 clk  in  1  system clock; single clock domain.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 enc_a  in  NUM_CH  quadrature A per channel; asynchronous.
REQ-009 enc_b  in  NUM_CH  quadrature B per channel; asynchronous.
REQ-010 enc_btn  in  NUM_CH  push-button per channel; asynchronous.
REQ-011 load_en  in  1  one-cycle request to preset one channel's count.
REQ-012 load_ch  in  3  channel index for load; indexes >= NUM_CH are ignored.
REQ-013 load_val  in  CNT_W  preset value; clamped to MAX_VAL of the target channel.
REQ-014 count  out  NUM_CH*CNT_W  registered per-channel position, ch0 in LSBs.
REQ-015 step_pulse  out  NUM_CH  one-cycle strobe when a channel's count changes due to rotation.
REQ-016 step_dir  out  NUM_CH  direction of the last step: 1 = up, 0 = down; valid with step_pulse.
REQ-017 btn_pulse  out  NUM_CH  one-cycle strobe on the debounced button press (rising edge).

Function
REQ-018 Each of enc_a, enc_b and enc_btn SHALL pass through a 2-FF synchroniser before use.
REQ-019 Each synchronised input SHALL be debounced by a counter. The debounced value updates only after the raw value has differed from it for DB_CYCLES consecutive cycles. Any bounce back restarts the counter at 0.
REQ-020 On a rising edge of debounced A, the count SHALL step up if debounced B = 0 and step down if debounced B = 1. All other edges are ignored (one step per detent).
REQ-021 Latency: a clean A edge SHALL appear on count and step_pulse exactly 2 + DB_CYCLES + 1 cycles after the raw input changes.
REQ-022 Saturate mode: up at MAX_VAL and down at 0 SHALL leave count unchanged and SHALL NOT assert step_pulse.
REQ-023 Wrap mode: up at MAX_VAL SHALL give 0, and down at 0 SHALL give MAX_VAL. step_pulse asserts in both cases.
REQ-024 A load with load_en=1 and a valid load_ch SHALL write min(load_val, MAX_VAL[ch]) on the next clock and SHALL NOT assert step_pulse.
REQ-025 If a load and a rotation step hit the same channel in the same cycle, the load SHALL win and the step SHALL be discarded.
REQ-026 Channels SHALL operate independently. Simultaneous steps on different channels SHALL all take effect in the same cycle.
REQ-027 btn_pulse SHALL fire once per press, whatever the press duration. Releases produce no pulse.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While rst=1, on each clock: count = 0 and step_pulse = step_dir = btn_pulse = 0. Synchroniser and debounced states = 0, and debounce counters = 0.
REQ-030 A reset asserted mid-debounce or mid-rotation SHALL discard the pending edge. No step SHALL occur after rst deasserts unless a new edge qualifies.
REQ-031 After rst deasserts, an input held at 1 SHALL be treated as a rising edge once it is debounced.

Structure
REQ-032 A shared package SHALL hold the default NUM_CH, CNT_W, DB_CYCLES and the default MAX_VAL/WRAP constants for the display (x 159, y 119, colour 255).
REQ-033 A sub-module enc_debounce (sync + debounce for one bit, with parameter DB_CYCLES) SHALL be instantiated 3*NUM_CH times via generate. The step/limit logic stays in pmod_enc_array.

Verification
REQ-034 Benches SHALL use DB_CYCLES=4.
REQ-035 Reset, then 5 clean detents A↑ with B=0 on ch0 -> count[7:0]=5, five step_pulses, step_dir=1, each 7 cycles after its raw edge.
REQ-036 ch1 (saturate, MAX 119) loaded with 119, then one up detent -> count stays 119 with no step_pulse. Load 0, then one down detent -> count stays 0.
REQ-037 ch2 (wrap, MAX 255) at 255, one up detent -> 0 with step_pulse and step_dir=1. At 0, one down detent -> 255.
REQ-038 A toggles 1-0-1-0 with each phase of 3 cycles, then stays high -> exactly one step, after the stable period.
REQ-039 Load ch0=200 (MAX 159) in the same cycle as a ch0 up step and a ch1 up step -> ch0=159, ch1 increments, ch1 step_pulse only. Also: button held 50 cycles -> single btn_pulse. Also: rst pulsed mid-debounce -> no step.

Source files
------------

// File: rtl/pmod_enc_array_pkg.sv
// Shared defaults for the PMOD rotary-encoder array (x / y / colour display channels).
package pmod_enc_array_pkg;

  localparam int NUM_CH_DEF    = 3;
  localparam int CNT_W_DEF     = 8;
  localparam int DB_CYCLES_DEF = 1000;

  localparam logic [7:0] MAX_X      = 8'd159;
  localparam logic [7:0] MAX_Y      = 8'd119;
  localparam logic [7:0] MAX_COLOUR = 8'd255;

  // ch0 = x, ch1 = y, ch2 = colour; only the colour channel wraps.
  localparam logic [3*8-1:0] MAX_VAL_DEF = {MAX_COLOUR, MAX_Y, MAX_X};
  localparam logic [2:0]     WRAP_DEF    = 3'b100;

  // Per-channel action chosen for the current cycle.
  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN,
    STEP_LOAD
  } step_act_e;

endpackage

// File: rtl/pmod_enc_array_if.sv
// Load request and registered outputs of the encoder array.
interface pmod_enc_array_if
  import pmod_enc_array_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic                    load_en;
  logic [2:0]              load_ch;
  logic [CNT_W-1:0]        load_val;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       step_pulse;
  logic [NUM_CH-1:0]       step_dir;
  logic [NUM_CH-1:0]       btn_pulse;

  modport master (
    output load_en, load_ch, load_val,
    input  count, step_pulse, step_dir, btn_pulse
  );

  modport slave (
    input  load_en, load_ch, load_val,
    output count, step_pulse, step_dir, btn_pulse
  );
endinterface

// File: rtl/pmod_enc_array_debounce.sv
// 2-FF synchroniser followed by a stability counter for one asynchronous bit.
module enc_debounce #(
  parameter int DB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Synchronise, then accept the new level only after DB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/pmod_enc_array.sv
// Array of quadrature encoders with per-channel saturate/wrap limits, preset load and button strobe.
module pmod_enc_array
  import pmod_enc_array_pkg::*;
#(
  parameter int                      NUM_CH    = NUM_CH_DEF,
  parameter int                      CNT_W     = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] MAX_VAL   = MAX_VAL_DEF,
  parameter logic [NUM_CH-1:0]       WRAP      = WRAP_DEF,
  parameter int                      DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] enc_a,
  input  logic [NUM_CH-1:0] enc_b,
  input  logic [NUM_CH-1:0] enc_btn,
  pmod_enc_array_if.slave   bus
);

  logic [NUM_CH-1:0] aDb, bDb, btnDb;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gCh
    localparam logic [CNT_W-1:0] MAXV  = MAX_VAL[ch*CNT_W +: CNT_W];
    localparam logic             WRAPM = WRAP[ch];

    enc_debounce #(.DB_CYCLES(DB_CYCLES)) uA   (.clk(clk), .rst(rst), .raw(enc_a[ch]),   .db(aDb[ch]));
    enc_debounce #(.DB_CYCLES(DB_CYCLES)) uB   (.clk(clk), .rst(rst), .raw(enc_b[ch]),   .db(bDb[ch]));
    enc_debounce #(.DB_CYCLES(DB_CYCLES)) uBtn (.clk(clk), .rst(rst), .raw(enc_btn[ch]), .db(btnDb[ch]));

    logic             aPrev, btnPrev;
    logic [CNT_W-1:0] cntQ, cntD, loadClamp;
    logic             pulseQ, pulseD, dirQ, dirD, btnQ;
    step_act_e        act;

    // Pick this cycle's action: a load on this channel overrides any rotation step.
    always_comb begin
      act       = STEP_NONE;
      loadClamp = (bus.load_val > MAXV) ? MAXV : bus.load_val;
      if (bus.load_en && (bus.load_ch == 3'(ch))) begin
        act = STEP_LOAD;
      end else if (aDb[ch] && !aPrev) begin
        act = bDb[ch] ? STEP_DOWN : STEP_UP;
      end
    end

    // Apply the action with saturate or wrap at the channel limits.
    always_comb begin
      cntD   = cntQ;
      pulseD = 1'b0;
      dirD   = dirQ;
      unique case (act)
        STEP_LOAD: cntD = loadClamp;
        STEP_UP: begin
          if (cntQ != MAXV) begin
            cntD = cntQ + CNT_W'(1); pulseD = 1'b1; dirD = 1'b1;
          end else if (WRAPM) begin
            cntD = '0; pulseD = 1'b1; dirD = 1'b1;
          end
        end
        STEP_DOWN: begin
          if (cntQ != '0) begin
            cntD = cntQ - CNT_W'(1); pulseD = 1'b1; dirD = 1'b0;
          end else if (WRAPM) begin
            cntD = MAXV; pulseD = 1'b1; dirD = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // Register count, strobes and edge-detect history.
    always_ff @(posedge clk) begin
      if (rst) begin
        cntQ    <= '0;
        pulseQ  <= 1'b0;
        dirQ    <= 1'b0;
        btnQ    <= 1'b0;
        aPrev   <= 1'b0;
        btnPrev <= 1'b0;
      end else begin
        cntQ    <= cntD;
        pulseQ  <= pulseD;
        dirQ    <= dirD;
        btnQ    <= btnDb[ch] & ~btnPrev;
        aPrev   <= aDb[ch];
        btnPrev <= btnDb[ch];
      end
    end

    assign bus.count[ch*CNT_W +: CNT_W] = cntQ;
    assign bus.step_pulse[ch]           = pulseQ;
    assign bus.step_dir[ch]             = dirQ;
    assign bus.btn_pulse[ch]            = btnQ;
  end

endmodule

// File: tb/tb_pmod_enc_array.sv
// Randomised scoreboard bench for pmod_enc_array with DB_CYCLES = 4.
module tb_pmod_enc_array;

  localparam int LAT = 7;  // 2 sync + 4 debounce + 1 output register

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] encA, encB, encBtn;
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;

  pmod_enc_array_if #(.NUM_CH(3), .CNT_W(8)) bus ();

  pmod_enc_array #(.DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .enc_a(encA), .enc_b(encB), .enc_btn(encBtn), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    int         cyc;
    logic [2:0] pulse;
    logic [2:0] dir;
    logic [2:0] btn;
    logic [23:0] cnt;
  } exp_t;

  exp_t q[$];

  // Reference model: plain per-channel positions and limits.
  int      m[3];
  int      maxv[3] = '{159, 119, 255};
  bit      wrapm[3] = '{1'b0, 1'b0, 1'b1};

  function automatic logic [23:0] packModel();
    return {m[2][7:0], m[1][7:0], m[0][7:0]};
  endfunction

  function automatic bit mstep(int ch, bit up);
    if (up) begin
      if (m[ch] < maxv[ch]) begin m[ch]++; return 1'b1; end
      if (wrapm[ch]) begin m[ch] = 0; return 1'b1; end
      return 1'b0;
    end
    if (m[ch] > 0) begin m[ch]--; return 1'b1; end
    if (wrapm[ch]) begin m[ch] = maxv[ch]; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare at each expected cycle, otherwise require no strobes.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("step_pulse", 32'(bus.step_pulse), 32'(e.pulse));
      chk("step_dir", 32'(bus.step_dir & e.pulse), 32'(e.dir));
      chk("btn_pulse", 32'(bus.btn_pulse), 32'(e.btn));
      chk("count", 32'(bus.count), 32'(e.cnt));
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("missed_event", 32'(cyc), 32'(e.cyc));
    end else if (!rst) begin
      chk("idle_strobes", 32'(bus.step_pulse | bus.btn_pulse), 32'd0);
    end
  end

  // One detent per channel in mask (direction per bit of up), optionally with a load landing on the same edge.
  task automatic rot(input logic [2:0] mask, input logic [2:0] up, input bit doLoad,
                     input logic [2:0] lch, input logic [7:0] lval);
    exp_t e;
    int   k;
    for (int ch = 0; ch < 3; ch++) if (mask[ch]) encB[ch] = ~up[ch];
    tick(8);
    k    = cyc;
    encA = encA | mask;
    tick(LAT - 1);
    e.cyc = k + LAT; e.pulse = '0; e.dir = '0; e.btn = '0;
    for (int ch = 0; ch < 3; ch++) begin
      if (doLoad && int'(lch) == ch) begin
        m[ch] = (int'(lval) > maxv[ch]) ? maxv[ch] : int'(lval);
      end else if (mask[ch]) begin
        if (mstep(ch, up[ch])) begin
          e.pulse[ch] = 1'b1;
          e.dir[ch]   = up[ch];
        end
      end
    end
    e.cnt = packModel();
    q.push_back(e);
    if (doLoad) begin
      bus.load_en = 1'b1; bus.load_ch = lch; bus.load_val = lval;
    end
    tick(1);
    bus.load_en = 1'b0;
    tick(1);
    encA = encA & ~mask;
    tick(8);
  endtask

  task automatic loadCh(input logic [2:0] ch, input logic [7:0] val);
    exp_t e;
    if (int'(ch) < 3) m[ch] = (int'(val) > maxv[ch]) ? maxv[ch] : int'(val);
    e.cyc = cyc + 1; e.pulse = '0; e.dir = '0; e.btn = '0; e.cnt = packModel();
    q.push_back(e);
    bus.load_en = 1'b1; bus.load_ch = ch; bus.load_val = val;
    tick(1);
    bus.load_en = 1'b0;
    tick(1);
  endtask

  initial begin
    exp_t e;
    int   k;
    rst = 1'b1; encA = '0; encB = '0; encBtn = '0;
    bus.load_en = 1'b0; bus.load_ch = '0; bus.load_val = '0;
    m = '{0, 0, 0};
    tick(3);
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_step_pulse", 32'(bus.step_pulse), 32'd0);
    chk("reset_step_dir", 32'(bus.step_dir), 32'd0);
    chk("reset_btn_pulse", 32'(bus.btn_pulse), 32'd0);
    rst = 1'b0;
    tick(2);

    // Five clean up detents on ch0.
    repeat (5) rot(3'b001, 3'b111, 1'b0, 3'd0, 8'd0);

    // ch1 saturates at both ends.
    loadCh(3'd1, 8'd119);
    rot(3'b010, 3'b111, 1'b0, 3'd0, 8'd0);
    loadCh(3'd1, 8'd0);
    rot(3'b010, 3'b000, 1'b0, 3'd0, 8'd0);

    // ch2 wraps at both ends.
    loadCh(3'd2, 8'd255);
    rot(3'b100, 3'b111, 1'b0, 3'd0, 8'd0);
    rot(3'b100, 3'b000, 1'b0, 3'd0, 8'd0);

    // Bouncing A on ch0: 3-cycle phases never qualify; the final high level gives one step.
    encB[0] = 1'b0;
    tick(8);
    k = cyc;
    for (int p = 0; p < 4; p++) begin
      encA[0] = (p % 2 == 0);
      tick(3);
    end
    encA[0] = 1'b1;
    void'(mstep(0, 1'b1));
    e.cyc = k + 12 + LAT; e.pulse = 3'b001; e.dir = 3'b001; e.btn = '0; e.cnt = packModel();
    q.push_back(e);
    tick(LAT + 2);
    encA[0] = 1'b0;
    tick(8);

    // Load ch0 past its limit on the same edge as ch0 and ch1 up steps.
    loadCh(3'd1, 8'd10);
    rot(3'b011, 3'b111, 1'b1, 3'd0, 8'd200);

    // Button held 50 cycles gives one pulse; release gives none.
    k = cyc;
    encBtn[1] = 1'b1;
    e.cyc = k + LAT; e.pulse = '0; e.dir = '0; e.btn = 3'b010; e.cnt = packModel();
    q.push_back(e);
    tick(50);
    encBtn[1] = 1'b0;
    tick(12);

    // Reset in the middle of an A debounce: nothing may step afterwards.
    encB[0] = 1'b0;
    tick(8);
    k = cyc;
    encA[0] = 1'b1;
    tick(3);
    rst = 1'b1;
    m = '{0, 0, 0};
    e.cyc = k + 6; e.pulse = '0; e.dir = '0; e.btn = '0; e.cnt = '0;
    q.push_back(e);
    tick(1);
    encA[0] = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(14);

    // Randomised detents, simultaneous channels and colliding loads (including invalid channels).
    for (int i = 0; i < 30; i++) begin
      logic [2:0] msk, dirs, lch;
      logic [7:0] lval;
      bit         dl;
      msk  = 3'($urandom_range(1, 7));
      dirs = 3'($urandom);
      dl   = ($urandom_range(0, 2) == 0);
      lch  = 3'($urandom_range(0, 7));
      lval = 8'($urandom);
      if ($urandom_range(0, 4) == 0) loadCh(3'($urandom_range(0, 3)), 8'($urandom));
      rot(msk, dirs, dl, lch, lval);
    end

    for (int w = 0; w < 100 && q.size() > 0; w++) tick(1);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
